// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
package uart_pkg;

  // Width of one received character.
  localparam int UART_DATA_BITS = 8;

  // Default number of receive FIFO entries (power of 2, at least 2).
  localparam int UART_DEPTH = 16;

  // Width of the saturating dropped-character counter.
  localparam int DROP_CNT_W = 8;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO.
// Writes are synchronous. Reads are asynchronous, so the entry at the read pointer
// appears on rdata without waiting for a clock edge (first-word fall-through).
// The array has no reset: nothing reads an entry until it has been written.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_DEPTH,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Store the incoming character at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive FIFO that sits behind the UART receiver.
// It buffers characters strobed in on rx_done and presents the oldest character on
// rd_data (first-word fall-through). When a character arrives while the FIFO is full
// and nothing is popped in the same cycle, the character is dropped. A dropped
// character sets the sticky overflow flag and increments a saturating drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int DEPTH     = UART_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       rx_data,
  input  logic                       rx_done,
  input  logic                       rd_ready,
  input  logic                       clr_overflow,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  push, pop, drop;

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = rd_valid & rd_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot this push needs.
  assign push     = rx_done & (~full | pop);
  assign drop     = rx_done & full & ~pop;

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Pointer and occupancy update. Pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Overflow bookkeeping. A drop in the same cycle as a clear wins: the flag stays set
  // and the counter restarts at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_cnt_d = DROP_CNT_W'(1);
      end else if (drop_cnt_q != DROP_MAX) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  uart_fifo_ram #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(rx_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo, checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_done = 1'b0;
  logic          rd_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [7:0]    drop_cnt;

  int vec  = 0;
  int errs = 0;

  // Reference model: contents in arrival order, overflow flag, drop count.
  logic [7:0] mq[$];
  bit         m_ovf  = 1'b0;
  int         m_drop = 0;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rd_ready    (rd_ready),
    .clr_overflow(clr_overflow),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus, advances the model, and returns the DUT head
  // sampled before the edge together with the character the model says was popped.
  task automatic step(input bit rxd, input logic [7:0] d, input bit rdy, input bit clr,
                      output logic [7:0] dut_head, output logic [7:0] exp_pop,
                      output bit popped);
    bit m_full, m_pop, m_push, m_drop_ev;
    rx_done      = rxd;
    rx_data      = d;
    rd_ready     = rdy;
    clr_overflow = clr;
    m_pop     = (mq.size() > 0) && rdy;
    m_full    = (mq.size() == DEPTH);
    m_push    = rxd && (!m_full || m_pop);
    m_drop_ev = rxd && m_full && !m_pop;
    popped    = m_pop;
    exp_pop   = m_pop ? mq[0] : 8'h00;
    dut_head  = rd_data;
    @(posedge clk);
    #1;
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back(d);
    if (m_drop_ev) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    rx_done      = 1'b0;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    vec++;
    if ({rd_valid, full, overflow} !== 3'b000 || count !== '0 || drop_cnt !== 8'd0) begin
      errs++;
      $display("FAIL reset_state: got valid=%b full=%b ovf=%b count=%0d drop=%0d want all 0",
               rd_valid, full, overflow, count, drop_cnt);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_single_push();
    logic [7:0] h, e;
    bit p;
    step(1'b1, 8'hA5, 1'b0, 1'b0, h, e, p);
    vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== CW'(1)) begin
      errs++;
      $display("FAIL single_push: got valid=%b data=%h count=%0d want 1 a5 1",
               rd_valid, rd_data, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, h, e, p);
    vec++;
    if (h !== 8'hA5 || rd_valid !== 1'b0 || count !== '0) begin
      errs++;
      $display("FAIL single_pop: got data=%h valid=%b count=%0d want a5 0 0", h, rd_valid, count);
    end
  endtask

  task automatic test_empty_push_pop();
    logic [7:0] h, e;
    bit p;
    step(1'b1, 8'h3C, 1'b1, 1'b0, h, e, p);
    vec++;
    if (count !== CW'(1) || rd_data !== 8'h3C || rd_valid !== 1'b1) begin
      errs++;
      $display("FAIL empty_push_pop: got count=%0d data=%h want 1 3c", count, rd_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, h, e, p);
  endtask

  task automatic fill_seq();
    logic [7:0] h, e;
    bit p;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, h, e, p);
  endtask

  task automatic drain_check(input string tag);
    logic [7:0] h, e;
    bit p;
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, h, e, p);
      vec++;
      if (h !== e) begin
        errs++;
        $display("FAIL %s_order[%0d]: got %h want %h", tag, i, h, e);
      end
    end
    vec++;
    if (rd_valid !== 1'b0 || count !== '0 || full !== 1'b0) begin
      errs++;
      $display("FAIL %s_empty: got valid=%b count=%0d full=%b want 0 0 0",
               tag, rd_valid, count, full);
    end
  endtask

  task automatic test_fill_drain();
    fill_seq();
    vec++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      errs++;
      $display("FAIL fill_full: got full=%b count=%0d want 1 %0d", full, count, DEPTH);
    end
    drain_check("drain");
  endtask

  task automatic test_overflow();
    logic [7:0] h, e;
    bit p;
    fill_seq();
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, h, e, p);
    vec++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd3 || rd_data !== 8'h00 || count !== CW'(DEPTH)) begin
      errs++;
      $display("FAIL overflow_set: got ovf=%b drop=%0d head=%h count=%0d want 1 3 00 %0d",
               overflow, drop_cnt, rd_data, count, DEPTH);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, h, e, p);
    vec++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || count !== CW'(DEPTH)) begin
      errs++;
      $display("FAIL overflow_clr: got ovf=%b drop=%0d count=%0d want 0 0 %0d",
               overflow, drop_cnt, count, DEPTH);
    end
    step(1'b1, 8'hEE, 1'b0, 1'b0, h, e, p);
    step(1'b1, 8'hEF, 1'b0, 1'b1, h, e, p);
    vec++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      errs++;
      $display("FAIL clr_drop_same: got ovf=%b drop=%0d want 1 1", overflow, drop_cnt);
    end
    for (int i = 0; i < 260; i++) step(1'b1, 8'h99, 1'b0, 1'b0, h, e, p);
    vec++;
    if (drop_cnt !== 8'd255 || drop_cnt !== 8'(m_drop)) begin
      errs++;
      $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, h, e, p);
  endtask

  task automatic test_full_push_pop();
    logic [7:0] h, e;
    bit p;
    logic [7:0] last;
    step(1'b1, 8'h55, 1'b1, 1'b0, h, e, p);
    vec++;
    if (h !== 8'h00 || count !== CW'(DEPTH) || overflow !== 1'b0 || full !== 1'b1) begin
      errs++;
      $display("FAIL full_push_pop: got pop=%h count=%0d ovf=%b want 00 %0d 0",
               h, count, overflow, DEPTH);
    end
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, h, e, p);
      vec++;
      if (h !== e) begin
        errs++;
        $display("FAIL full_pp_order[%0d]: got %h want %h", i, h, e);
      end
      last = h;
    end
    vec++;
    if (last !== 8'h55) begin
      errs++;
      $display("FAIL full_pp_last: got %h want 55", last);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] h, e;
    bit p;
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, h, e, p);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, h, e, p);
      vec++;
      if (h !== e || count !== CW'(3)) begin
        errs++;
        $display("FAIL wrap[%0d]: got data=%h count=%0d want %h 3", i, h, count, e);
      end
    end
    drain_check("wrap");
  endtask

  task automatic test_mid_reset();
    logic [7:0] h, e;
    bit p;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, h, e, p);
    vec++;
    if (count !== CW'(5)) begin
      errs++;
      $display("FAIL mid_reset_pre: got count=%0d want 5", count);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (count !== '0 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_async: got count=%0d valid=%b full=%b ovf=%b want 0 0 0 0",
               count, rd_valid, full, overflow);
    end
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    step(1'b1, 8'h77, 1'b0, 1'b0, h, e, p);
    vec++;
    if (count !== CW'(1) || rd_data !== 8'h77) begin
      errs++;
      $display("FAIL post_reset_push: got count=%0d data=%h want 1 77", count, rd_data);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, h, e, p);
  endtask

  task automatic test_random();
    logic [7:0] h, e;
    bit p, rxd, rdy, clr;
    int push_pct, pop_pct;
    for (int i = 0; i < 2000; i++) begin
      push_pct = ((i / 250) % 2 == 0) ? 75 : 30;
      pop_pct  = ((i / 250) % 2 == 0) ? 30 : 75;
      rxd = ($urandom_range(0, 99) < push_pct);
      rdy = ($urandom_range(0, 99) < pop_pct);
      clr = ($urandom_range(0, 99) < 4);
      step(rxd, 8'($urandom), rdy, clr, h, e, p);
      vec++;
      if ((p && h !== e) || count !== CW'(mq.size()) || rd_valid !== (mq.size() != 0) ||
          full !== (mq.size() == DEPTH) || overflow !== m_ovf || drop_cnt !== 8'(m_drop) ||
          (mq.size() != 0 && rd_data !== mq[0])) begin
        errs++;
        $display("FAIL random[%0d]: got pop=%h cnt=%0d ovf=%b drop=%0d head=%h want pop=%h cnt=%0d ovf=%b drop=%0d",
                 i, h, count, overflow, drop_cnt, rd_data, e, mq.size(), m_ovf, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_empty_push_pop();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the width of one received character.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries; it must be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_data, input, DATA_BITS bits: received character from the UART receiver.
REQ-006 SHALL have port rx_done, input, 1 bit: one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port rd_ready, input, 1 bit: the consumer accepts rd_data this cycle.
REQ-008 SHALL have port clr_overflow, input, 1 bit: clears overflow and drop_cnt.
REQ-009 SHALL have port rd_data, output, DATA_BITS bits: head-of-FIFO character (first-word fall-through).
REQ-010 SHALL have port rd_valid, output, 1 bit: FIFO non-empty, so rd_data is valid.
REQ-011 SHALL have port count, output, clog2(DEPTH+1) bits: current occupancy.
REQ-012 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, set when a character is dropped.
REQ-014 SHALL have port drop_cnt, output, 8 bits: number of dropped characters, saturating.

Function
REQ-015 SHALL push on a clk edge when rx_done=1 and (full=0 or a pop occurs in the same cycle).
REQ-016 SHALL pop on a clk edge when rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 SHALL be ignored.
REQ-017 SHALL present a pushed character on rd_data with rd_valid=1 exactly 1 cycle after the rx_done edge when the FIFO was empty; there is no same-cycle bypass.
REQ-018 SHALL drive rd_data directly from the entry at the read pointer; it SHALL be stable while rd_valid=1 and no pop occurs.
REQ-019 SHALL update count +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-020 SHALL wrap the write and read pointers modulo DEPTH; wrap SHALL NOT corrupt data ordering, which is strictly FIFO.
REQ-021 SHALL accept a simultaneous push and pop when full: both occur and count stays at DEPTH.
REQ-022 SHALL, when empty with rx_done=1 and rd_ready=1 in the same cycle, push only; count becomes 1.
REQ-023 SHALL, on rx_done=1 with full=1 and no pop, discard the character, set overflow, and increment drop_cnt, saturating at 255.
REQ-024 SHALL clear overflow and drop_cnt on clr_overflow=1; if a drop occurs in the same cycle, overflow=1 and drop_cnt=1 (the set takes priority).
REQ-025 SHALL NOT alter the stored data, pointers or count when clr_overflow is asserted.

Reset
REQ-026 SHALL, while rst=0, asynchronously force pointers=0, count=0, rd_valid=0, full=0, overflow=0 and drop_cnt=0.
REQ-027 SHALL discard all buffered characters when reset is asserted mid-operation; rd_data is don't-care while rd_valid=0.
REQ-028 SHALL NOT require storage-array contents to be reset.
REQ-029 SHALL ignore rx_done during the first edge after rst deasserts only if it coincides with the deassertion; the following edge SHALL push normally.

Structure
REQ-030 SHALL take DATA_BITS and the DEPTH default from the shared uart_pkg package, which also holds the drop-counter width constant (8).
REQ-031 SHALL instantiate one sub-module, uart_fifo_ram: a DEPTH x DATA_BITS array with a synchronous write port and an asynchronous read port.
REQ-032 SHALL keep pointer, count and flag logic in uart_rx_fifo; no other sub-modules are used.

Verification
REQ-033 SHALL cover single push: 0xA5 with rd_ready=0 -> rd_valid=1 and rd_data=0xA5 one cycle later, count=1.
REQ-034 SHALL cover fill and drain: push 0x00..0x0F -> full=1, count=16; then rd_ready=1 for 16 cycles -> 0x00..0x0F in order, ending rd_valid=0, count=0.
REQ-035 SHALL cover overflow: FIFO full, push 3 more with no pop -> overflow=1, drop_cnt=3, head unchanged; clr_overflow -> both return to 0.
REQ-036 SHALL cover simultaneous push and pop when full: push 0x55 while popping 0x00 -> count stays 16, overflow=0, and 0x55 is read last.
REQ-037 SHALL cover wrap-around: 40 push/pop pairs at occupancy 3 -> output sequence identical to the input, count=3 throughout.
REQ-038 SHALL cover mid-operation reset: count=5, rst=0 for 1 cycle -> count=0, rd_valid=0, full=0, overflow=0 immediately (asynchronously).
